ipif_param_streamer: RTL and testbench
======================================

Name: ipif_param_streamer

Overview:
Single-clock serializer that snapshots a wide IPIF parameter vector (N_REG words of C_S_AXI_DATA_WIDTH) and streams it as indexed words over a valid/ready channel. It feeds narrow CDC FIFOs and serial links, so parameter banks wider than one handshake need no wide CDC primitive. Each sweep is coherent: all words come from one snapshot cycle.

Parameters:
C_S_AXI_DATA_WIDTH, 32, width of one register word and of out_data
N_REG, 2, number of words in the parameter vector (>=1)
GAP_CYCLES, 0, idle cycles inserted between consecutive sweeps (0..65535)
REFRESH_SWEEPS, 16, with change-only enabled: every REFRESH_SWEEPS-th snapshot sends all words (>=1)

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high reset
params_in  in  N_REG*C_S_AXI_DATA_WIDTH  flat parameter vector; word k = params_in[k*W +: W]
enable  in  1  start/continue sweeping
out_valid  out  1  beat valid
out_ready  in  1  downstream accepts beat
out_data  out  C_S_AXI_DATA_WIDTH  word value
out_idx  out  IDX_W = max(1,$clog2(N_REG))  word index
out_first  out  1  first beat of sweep
out_last  out  1  last beat of sweep
sweep_count  out  16  completed sweeps, wraps 0xFFFF->0
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (clk edge with reset=1) forces IDLE. All outputs are 0 from that edge. Snapshot and idx are cleared. Applies mid-sweep too: the beat in flight is dropped, not completed.
- FSM states: IDLE, SNAP, SEND, GAP.
- IDLE: enable=1 -> SNAP.
- SNAP (1 cycle): capture params_in into the snapshot register, set idx to the first word to send -> SEND.
- SEND: out_valid=1. out_data = snapshot word idx, out_idx = idx.
  - out_first=1 on the first beat of the sweep; out_last=1 on the final beat.
  - Beat transfers when out_valid & out_ready.
  - While waiting for out_ready, out_valid, out_data, out_idx, out_first and out_last hold stable.
  - After the last beat: sweep_count++. Then SNAP if GAP_CYCLES==0 && enable; GAP if GAP_CYCLES>0; otherwise IDLE.
- GAP: down-counter loaded with GAP_CYCLES. At 0: SNAP if enable, else IDLE.
- enable=0 mid-sweep: the current sweep completes; it is never truncated.
- Latency: enable rises at cycle n -> SNAP at n+1 -> first out_valid at n+2.
- With out_ready held high: sweep length N_REG cycles; period N_REG+1+GAP_CYCLES.
- Snapshot semantics: params_in changes during SEND/GAP do not affect the current sweep.
- N_REG=1: every beat has out_first=out_last=1 and out_idx=0.

Optional Feature:
IPIF_STREAM_CHANGE_ONLY_EN.
- Defined:
  - Keep a last_sent copy of every word (reset to 0).
  - At SNAP, compute mask[k] = (snapshot word k != last_sent word k).
  - Force mask to all ones on the first sweep after reset and on every REFRESH_SWEEPS-th snapshot (refresh counter counts SNAP entries).
  - SEND emits only words with mask set, ascending idx. Skipped words cost 0 cycles (next-set-bit lookahead).
  - out_first marks the lowest set bit; out_last marks the highest.
  - last_sent[k] updates when its beat transfers.
  - Mask all zero: SNAP goes straight to GAP (or SNAP/IDLE per the rules above); no beats, sweep_count unchanged.
- Undefined: all N_REG words are sent every sweep, and no last_sent storage is built.

Decomposition:
- Package ipif_stream_pkg holds:
  - state enum (IDLE, SNAP, SEND, GAP)
  - idx-width function max(1,$clog2(n))
  - sweep_count width constant (16)
- One sub-module: ipif_next_set_bit, a combinational priority encoder. It returns the lowest set bit of mask above a given index and a none-found flag. It is instantiated only under IPIF_STREAM_CHANGE_ONLY_EN.

Test Plan:
1. N_REG=4, W=32, params words {0x11,0x22,0x33,0x44}, enable=1, out_ready=1 -> beats idx 0..3 data 0x11..0x44. First out_valid 2 cycles after enable. first on idx0, last on idx3, sweep_count=1 after 4 beats.
2. out_ready toggles 1,0,0,1 during a sweep; params_in word1 changed to 0xAA mid-sweep -> outputs held stable while stalled. The current sweep sends the old word1; the next sweep sends 0xAA.
3. GAP_CYCLES=3, out_ready=1 -> 4 idle cycles between last and next first beat (3 GAP + 1 SNAP). Drop enable during a sweep -> sweep completes, FSM reaches IDLE, busy=0.
4. Assert reset on the 2nd beat of a sweep -> out_valid=0 and sweep_count=0 from that edge. Re-enable -> a fresh sweep starts at idx0.
5. sweep_count preset near wrap (run 65535 sweeps, N_REG=1) -> count wraps to 0 on the next completed sweep.
6. With IPIF_STREAM_CHANGE_ONLY_EN, REFRESH_SWEEPS=4, N_REG=4:
   - First sweep sends all 4 words.
   - Change only word2 -> next sweep emits one beat idx2 with first=last=1.
   - Unchanged sweeps emit nothing.
   - The 4th snapshot sends all 4 words.

Source files
------------

// File: rtl/ipif_stream_pkg.sv
// Shared types and sizing helpers for the IPIF parameter streamer.
package ipif_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SNAP = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int SWEEP_CNT_W = 16;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ipif_next_set_bit.sv
// Combinational priority encoder: lowest set bit of mask above base_idx
// (or at base_idx when inclusive), with a none-found flag.
module ipif_next_set_bit #(
    parameter int N     = 2,
    parameter int IDX_W = 1
)(
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] base_idx,
    input  logic             inclusive,
    output logic [IDX_W-1:0] found_idx,
    output logic             none
);

    // Scanning downward lets the lowest qualifying bit win.
    always_comb begin
        found_idx = '0;
        none      = 1'b1;
        for (int k = N - 1; k >= 0; k--) begin
            if (mask[k] && ((k > int'(base_idx)) || (inclusive && (k == int'(base_idx))))) begin
                found_idx = IDX_W'(k);
                none      = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ipif_param_streamer.sv
// Snapshots a wide IPIF parameter vector and streams it as indexed words.
// Define IPIF_STREAM_CHANGE_ONLY_EN to send only words changed since last sent.
module ipif_param_streamer
    import ipif_stream_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int N_REG              = 2,
    parameter int GAP_CYCLES         = 0,
    parameter int REFRESH_SWEEPS     = 16,
    localparam int IDX_W             = idx_width(N_REG)
)(
    input  logic                                clk,
    input  logic                                reset,
    input  logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] params_in,
    input  logic                                enable,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       out_data,
    output logic [IDX_W-1:0]                    out_idx,
    output logic                                out_first,
    output logic                                out_last,
    output logic [SWEEP_CNT_W-1:0]              sweep_count,
    output logic                                busy
);

    localparam int W = C_S_AXI_DATA_WIDTH;

    state_t                   state, state_nxt;
    logic [N_REG*W-1:0]       snap_q;
    logic [IDX_W-1:0]         idx_q;
    logic                     first_q;
    logic [SWEEP_CNT_W-1:0]   sweep_cnt_q;
    logic [15:0]              gap_cnt_q;

    logic                     beat_fire;
    logic [IDX_W-1:0]         first_idx;
    logic [IDX_W-1:0]         next_idx;
    logic                     at_last;
    logic                     snap_empty;
    state_t                   after_sweep;

    assign beat_fire = (state == SEND) && out_ready;

`ifdef IPIF_STREAM_CHANGE_ONLY_EN
    localparam int REF_W = idx_width(REFRESH_SWEEPS);

    logic [N_REG*W-1:0] last_sent_q;
    logic [N_REG-1:0]   mask_q;
    logic [N_REG-1:0]   snap_mask;
    logic [REF_W-1:0]   refresh_cnt_q;
    logic               first_snap_q;
    logic               refresh;
    logic [N_REG-1:0]   enc_mask;
    logic [IDX_W-1:0]   enc_base;
    logic [IDX_W-1:0]   enc_idx;
    logic               enc_none;

    assign refresh = first_snap_q || (refresh_cnt_q == REF_W'(REFRESH_SWEEPS - 1));

    always_comb begin
        snap_mask = '0;
        for (int k = 0; k < N_REG; k++) begin
            snap_mask[k] = refresh || (params_in[k*W +: W] != last_sent_q[k*W +: W]);
        end
    end

    // One encoder serves both lookups: first word at SNAP, successor during SEND.
    assign enc_mask = (state == SNAP) ? snap_mask : mask_q;
    assign enc_base = (state == SNAP) ? '0 : idx_q;

    ipif_next_set_bit #(
        .N     (N_REG),
        .IDX_W (IDX_W)
    ) u_next_set_bit (
        .mask      (enc_mask),
        .base_idx  (enc_base),
        .inclusive (state == SNAP),
        .found_idx (enc_idx),
        .none      (enc_none)
    );

    assign first_idx  = enc_idx;
    assign next_idx   = enc_idx;
    assign at_last    = enc_none;
    assign snap_empty = enc_none;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_sent_q   <= '0;
            mask_q        <= '0;
            refresh_cnt_q <= '0;
            first_snap_q  <= 1'b1;
        end else begin
            if (state == SNAP) begin
                mask_q        <= snap_mask;
                first_snap_q  <= 1'b0;
                refresh_cnt_q <= (refresh_cnt_q == REF_W'(REFRESH_SWEEPS - 1)) ?
                                 '0 : refresh_cnt_q + REF_W'(1);
            end
            if (beat_fire) begin
                last_sent_q[int'(idx_q)*W +: W] <= snap_q[int'(idx_q)*W +: W];
            end
        end
    end
`else
    assign first_idx  = '0;
    assign next_idx   = idx_q + IDX_W'(1);
    assign at_last    = (idx_q == IDX_W'(N_REG - 1));
    assign snap_empty = 1'b0;
`endif

    assign after_sweep = (GAP_CYCLES > 0) ? GAP : (enable ? SNAP : IDLE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (enable) state_nxt = SNAP;
            SNAP: state_nxt = snap_empty ? after_sweep : SEND;
            SEND: if (beat_fire && at_last) state_nxt = after_sweep;
            GAP:  if (gap_cnt_q == '0) state_nxt = enable ? SNAP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The gap counter is loaded one short so GAP lasts exactly GAP_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            snap_q      <= '0;
            idx_q       <= '0;
            first_q     <= 1'b0;
            sweep_cnt_q <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                SNAP: begin
                    snap_q  <= params_in;
                    idx_q   <= first_idx;
                    first_q <= 1'b1;
                end
                SEND: begin
                    if (beat_fire) begin
                        first_q <= 1'b0;
                        if (at_last) begin
                            sweep_cnt_q <= sweep_cnt_q + SWEEP_CNT_W'(1);
                        end else begin
                            idx_q <= next_idx;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_q != '0) gap_cnt_q <= gap_cnt_q - 16'd1;
                end
                default: ;
            endcase
            if ((state_nxt == GAP) && (state != GAP)) begin
                gap_cnt_q <= 16'(GAP_CYCLES - 1);
            end
        end
    end

    assign out_valid   = (state == SEND);
    assign out_data    = (state == SEND) ? snap_q[int'(idx_q)*W +: W] : '0;
    assign out_idx     = (state == SEND) ? idx_q : '0;
    assign out_first   = (state == SEND) && first_q;
    assign out_last    = (state == SEND) && at_last;
    assign sweep_count = sweep_cnt_q;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_ipif_param_streamer.sv
// Directed bench for ipif_param_streamer; the change-only scenario runs only
// when IPIF_STREAM_CHANGE_ONLY_EN is defined.
module tb_ipif_param_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic         reset_a, en_a, rdy_a, valid_a, first_a, last_a, busy_a;
    logic [127:0] params_a;
    logic [1:0]   idx_a;
    logic [31:0]  data_a;
    logic [15:0]  cnt_a;

    logic         reset_g, en_g, rdy_g, valid_g, first_g, last_g, busy_g;
    logic [127:0] params_g;
    logic [1:0]   idx_g;
    logic [31:0]  data_g;
    logic [15:0]  cnt_g;

    logic         reset_one, en_one, rdy_one, valid_one, first_one, last_one, busy_one;
    logic [31:0]  params_one;
    logic [0:0]   idx_one;
    logic [31:0]  data_one;
    logic [15:0]  cnt_one;

    // REFRESH_SWEEPS=1 keeps these instances sending every word even with change-only built in.
    ipif_param_streamer #(.C_S_AXI_DATA_WIDTH(32), .N_REG(4), .GAP_CYCLES(0), .REFRESH_SWEEPS(1)) dut_a (
        .clk(clk), .reset(reset_a), .params_in(params_a), .enable(en_a),
        .out_valid(valid_a), .out_ready(rdy_a), .out_data(data_a), .out_idx(idx_a),
        .out_first(first_a), .out_last(last_a), .sweep_count(cnt_a), .busy(busy_a));

    ipif_param_streamer #(.C_S_AXI_DATA_WIDTH(32), .N_REG(4), .GAP_CYCLES(3), .REFRESH_SWEEPS(1)) dut_g (
        .clk(clk), .reset(reset_g), .params_in(params_g), .enable(en_g),
        .out_valid(valid_g), .out_ready(rdy_g), .out_data(data_g), .out_idx(idx_g),
        .out_first(first_g), .out_last(last_g), .sweep_count(cnt_g), .busy(busy_g));

    ipif_param_streamer #(.C_S_AXI_DATA_WIDTH(32), .N_REG(1), .GAP_CYCLES(0), .REFRESH_SWEEPS(1)) dut_one (
        .clk(clk), .reset(reset_one), .params_in(params_one), .enable(en_one),
        .out_valid(valid_one), .out_ready(rdy_one), .out_data(data_one), .out_idx(idx_one),
        .out_first(first_one), .out_last(last_one), .sweep_count(cnt_one), .busy(busy_one));

`ifdef IPIF_STREAM_CHANGE_ONLY_EN
    logic         reset_c, en_c, rdy_c, valid_c, first_c, last_c, busy_c;
    logic [127:0] params_c;
    logic [1:0]   idx_c;
    logic [31:0]  data_c;
    logic [15:0]  cnt_c;

    ipif_param_streamer #(.C_S_AXI_DATA_WIDTH(32), .N_REG(4), .GAP_CYCLES(0), .REFRESH_SWEEPS(4)) dut_c (
        .clk(clk), .reset(reset_c), .params_in(params_c), .enable(en_c),
        .out_valid(valid_c), .out_ready(rdy_c), .out_data(data_c), .out_idx(idx_c),
        .out_first(first_c), .out_last(last_c), .sweep_count(cnt_c), .busy(busy_c));
`endif

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] beat(input logic v, input logic f, input logic l,
                                         input logic [1:0] i, input logic [31:0] d);
        return {27'd0, v, f, l, i, d};
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset_a = 1'b1; en_a = 1'b0; rdy_a = 1'b0; params_a = '0;
        reset_g = 1'b1; en_g = 1'b0; rdy_g = 1'b0; params_g = '0;
        reset_one = 1'b1; en_one = 1'b0; rdy_one = 1'b0; params_one = '0;
`ifdef IPIF_STREAM_CHANGE_ONLY_EN
        reset_c = 1'b1; en_c = 1'b0; rdy_c = 1'b0; params_c = '0;
`endif
        applyStimulus(2);
        checkOutput("reset_a_outputs", beat(valid_a, first_a, last_a, idx_a, data_a), beat(0, 0, 0, 2'd0, 32'h0));
        checkOutput("reset_a_busy_cnt", {busy_a, cnt_a}, {1'b0, 16'h0});
        reset_a = 1'b0; reset_g = 1'b0; reset_one = 1'b0;
`ifdef IPIF_STREAM_CHANGE_ONLY_EN
        reset_c = 1'b0;
`endif

        // Basic sweep: latency, beat order, first/last, count.
        params_a = {32'h44, 32'h33, 32'h22, 32'h11};
        rdy_a = 1'b1; en_a = 1'b1;
        applyStimulus(1);
        checkOutput("t1_snap_cycle", {busy_a, valid_a}, 2'b10);
        applyStimulus(1);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("t1_beat%0d", k), beat(valid_a, first_a, last_a, idx_a, data_a),
                        beat(1'b1, k == 0, k == 3, 2'(k), 32'h11 * (k + 1)));
            applyStimulus(1);
        end
        checkOutput("t1_count", cnt_a, 16'd1);
        checkOutput("t1_resnap_no_valid", valid_a, 1'b0);

        // Backpressure and mid-sweep parameter change.
        applyStimulus(1);
        checkOutput("t2_beat0", beat(valid_a, first_a, last_a, idx_a, data_a), beat(1, 1, 0, 2'd0, 32'h11));
        applyStimulus(1);
        checkOutput("t2_beat1", beat(valid_a, first_a, last_a, idx_a, data_a), beat(1, 0, 0, 2'd1, 32'h22));
        rdy_a = 1'b0;
        params_a[63:32] = 32'hAA;
        applyStimulus(1);
        checkOutput("t2_stall1", beat(valid_a, first_a, last_a, idx_a, data_a), beat(1, 0, 0, 2'd1, 32'h22));
        applyStimulus(1);
        checkOutput("t2_stall2", beat(valid_a, first_a, last_a, idx_a, data_a), beat(1, 0, 0, 2'd1, 32'h22));
        rdy_a = 1'b1;
        applyStimulus(1);
        checkOutput("t2_beat2", beat(valid_a, first_a, last_a, idx_a, data_a), beat(1, 0, 0, 2'd2, 32'h33));
        applyStimulus(1);
        checkOutput("t2_beat3", beat(valid_a, first_a, last_a, idx_a, data_a), beat(1, 0, 1, 2'd3, 32'h44));
        applyStimulus(1);
        checkOutput("t2_count", {valid_a, cnt_a}, {1'b0, 16'd2});
        applyStimulus(1);
        checkOutput("t2_next_beat0", beat(valid_a, first_a, last_a, idx_a, data_a), beat(1, 1, 0, 2'd0, 32'h11));
        en_a = 1'b0;
        applyStimulus(1);
        checkOutput("t2_next_beat1_new", beat(valid_a, first_a, last_a, idx_a, data_a), beat(1, 0, 0, 2'd1, 32'hAA));
        applyStimulus(2);
        checkOutput("t2_next_beat3", beat(valid_a, first_a, last_a, idx_a, data_a), beat(1, 0, 1, 2'd3, 32'h44));
        applyStimulus(1);
        checkOutput("t3_disable_idle", {busy_a, valid_a, cnt_a}, {1'b0, 1'b0, 16'd3});

        // Reset on the second beat drops the sweep; a fresh one starts at idx0.
        en_a = 1'b1;
        applyStimulus(3);
        checkOutput("t4_second_beat", beat(valid_a, first_a, last_a, idx_a, data_a), beat(1, 0, 0, 2'd1, 32'hAA));
        reset_a = 1'b1;
        applyStimulus(1);
        checkOutput("t4_reset_outputs", beat(valid_a, first_a, last_a, idx_a, data_a), beat(0, 0, 0, 2'd0, 32'h0));
        checkOutput("t4_reset_count", {busy_a, cnt_a}, {1'b0, 16'd0});
        reset_a = 1'b0;
        applyStimulus(2);
        checkOutput("t4_fresh_beat0", beat(valid_a, first_a, last_a, idx_a, data_a), beat(1, 1, 0, 2'd0, 32'h11));
        en_a = 1'b0;
        for (int i = 0; i < 20 && busy_a; i++) applyStimulus(1);
        checkOutput("t4_fresh_done", {busy_a, cnt_a}, {1'b0, 16'd1});

        // Gap of 3 cycles: 4 idle cycles between last and next first beat.
        params_g = {32'hD4, 32'hC3, 32'hB2, 32'hA1};
        rdy_g = 1'b1; en_g = 1'b1;
        applyStimulus(2);
        checkOutput("t3_g_beat0", beat(valid_g, first_g, last_g, idx_g, data_g), beat(1, 1, 0, 2'd0, 32'hA1));
        applyStimulus(3);
        checkOutput("t3_g_beat3", beat(valid_g, first_g, last_g, idx_g, data_g), beat(1, 0, 1, 2'd3, 32'hD4));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1);
            checkOutput($sformatf("t3_g_idle%0d", i), {busy_g, valid_g}, 2'b10);
        end
        checkOutput("t3_g_count", cnt_g, 16'd1);
        applyStimulus(1);
        checkOutput("t3_g_next_first", beat(valid_g, first_g, last_g, idx_g, data_g), beat(1, 1, 0, 2'd0, 32'hA1));
        applyStimulus(1);
        en_g = 1'b0;
        applyStimulus(2);
        checkOutput("t3_g_last_after_disable", beat(valid_g, first_g, last_g, idx_g, data_g), beat(1, 0, 1, 2'd3, 32'hD4));
        applyStimulus(3);
        checkOutput("t3_g_in_gap", {busy_g, valid_g}, 2'b10);
        applyStimulus(1);
        checkOutput("t3_g_idle", {busy_g, valid_g, cnt_g}, {1'b0, 1'b0, 16'd2});

        // Count wrap with a single-word vector, starting from a preset count.
        params_one = 32'hCAFE0001;
        rdy_one = 1'b1;
        force dut_one.sweep_cnt_q = 16'hFFFE;
        applyStimulus(1);
        release dut_one.sweep_cnt_q;
        applyStimulus(1);
        checkOutput("t5_preset", cnt_one, 16'hFFFE);
        en_one = 1'b1;
        applyStimulus(2);
        checkOutput("t5_single_beat", beat(valid_one, first_one, last_one, {1'b0, idx_one}, data_one),
                    beat(1, 1, 1, 2'd0, 32'hCAFE0001));
        applyStimulus(1);
        checkOutput("t5_count_ffff", cnt_one, 16'hFFFF);
        applyStimulus(1);
        checkOutput("t5_second_beat", beat(valid_one, first_one, last_one, {1'b0, idx_one}, data_one),
                    beat(1, 1, 1, 2'd0, 32'hCAFE0001));
        en_one = 1'b0;
        applyStimulus(1);
        checkOutput("t5_wrap", {busy_one, cnt_one}, {1'b0, 16'h0000});

`ifdef IPIF_STREAM_CHANGE_ONLY_EN
        // Change-only: full first sweep, one changed word, empty sweep, refresh on 4th snapshot.
        params_c = {32'h44, 32'h33, 32'h22, 32'h11};
        rdy_c = 1'b1; en_c = 1'b1;
        applyStimulus(2);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("t6_full_beat%0d", k), beat(valid_c, first_c, last_c, idx_c, data_c),
                        beat(1'b1, k == 0, k == 3, 2'(k), 32'h11 * (k + 1)));
            if (k == 3) params_c[95:64] = 32'h55;
            applyStimulus(1);
        end
        checkOutput("t6_snap2", {valid_c, cnt_c}, {1'b0, 16'd1});
        applyStimulus(1);
        checkOutput("t6_changed_only", beat(valid_c, first_c, last_c, idx_c, data_c), beat(1, 1, 1, 2'd2, 32'h55));
        applyStimulus(1);
        checkOutput("t6_empty_snap3", {busy_c, valid_c, cnt_c}, {1'b1, 1'b0, 16'd2});
        applyStimulus(1);
        checkOutput("t6_snap4", {busy_c, valid_c, cnt_c}, {1'b1, 1'b0, 16'd2});
        applyStimulus(1);
        en_c = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("t6_refresh_beat%0d", k), beat(valid_c, first_c, last_c, idx_c, data_c),
                        beat(1'b1, k == 0, k == 3, 2'(k), (k == 2) ? 32'h55 : 32'h11 * (k + 1)));
            applyStimulus(1);
        end
        checkOutput("t6_done", {busy_c, cnt_c}, {1'b0, 16'd3});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
